sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised synchronous FIFO, the next generation of the cache's buffering queue. It adds full/empty protection, programmable almost-full/almost-empty thresholds, a synchronous flush and optional sticky error reporting. It sits between cache request/response producers and consumers in a single clock domain. Read data is show-ahead: the head entry is always visible on `data_out`.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_THRESH`, 12, `almost_full` asserts when `cnt` ≥ this value (1..DEPTH)
- `AE_THRESH`, 4, `almost_empty` asserts when `cnt` ≤ this value (0..DEPTH-1)
- Derived: `PTR_W` = $clog2(DEPTH); `CNT_W` = PTR_W+1

- `clk`  in  1  the single clock; all state changes on its rising edge
- `FIFO_clr`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of pointers, count and error flags
- `push`  in  1  write request
- `pop`  in  1  read request
- `data_in`  in  WIDTH  write data
- `err_clr`  in  1  synchronous clear of sticky error flags
- `data_out`  out  WIDTH  head entry (mem[rd_ptr])
- `cnt`  out  CNT_W  current occupancy, 0..DEPTH
- `full`  out  1  `cnt` == DEPTH
- `empty`  out  1  `cnt` == 0
- `almost_full`  out  1  `cnt` ≥ AF_THRESH
- `almost_empty`  out  1  `cnt` ≤ AE_THRESH
- `overflow`  out  1  sticky: a push was rejected because the FIFO was full
- `underflow`  out  1  sticky: a pop was rejected because the FIFO was empty

## Operation
- Storage: DEPTH×WIDTH register array. Write pointer `wr_ptr` and read pointer `rd_ptr` are PTR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Qualified requests:
  - push_ok = push & (!full | pop)
  - pop_ok = pop & !empty
- Push+pop when full: both are accepted. The head is popped and the new data is written to the slot at `wr_ptr`; `cnt` stays at DEPTH.
- Push+pop when empty: the push is accepted and the pop is rejected, which counts as an underflow. `cnt` becomes 1.
- Push accepted: mem[wr_ptr] ← data_in, wr_ptr+1.
- Pop accepted: rd_ptr+1.
- Count update: `cnt` +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Priority, highest first: `FIFO_clr` (async), then `flush`, then `err_clr`/push/pop. `err_clr` and push/pop act in the same cycle; push/pop are processed normally alongside `err_clr`.
- `FIFO_clr`: pointers, `cnt`, every memory entry and both error flags go to 0.
- `flush`: pointers, `cnt` and error flags go to 0. Memory contents are retained. Any push/pop in the same cycle is ignored and flagged as neither overflow nor underflow.
- Error flags: set on a rejected request, held until `err_clr`, `flush` or `FIFO_clr`. A set in the same cycle as `err_clr` wins, so the flag stays 1.
- All status outputs are combinational decodes of the registered `cnt`.

## Timing
- Reset values: `cnt`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (AF_THRESH≥1), `overflow`=0, `underflow`=0, `data_out`=0.
- Write-to-read latency is 1 cycle. Data pushed at edge N appears on `data_out` after edge N when the FIFO was empty.
- A pop at edge N advances `data_out` to the next entry immediately after edge N.
- Status flags reflect accepted operations one cycle after the request edge. There are no combinational paths from `push`/`pop` to the flags.
- A `FIFO_clr` asserted mid-operation aborts immediately. Deassertion is synchronised externally.

## Configuration
- `SYNC_FIFO_ERR_EN`
  - Defined: `overflow`/`underflow` sticky logic and `err_clr` are implemented as described.
  - Undefined: the ports remain, `overflow` and `underflow` are tied to 0, and `err_clr` is ignored. Rejection of illegal push/pop is unchanged.

## Test plan
- Reset, then push 0x01..0x10 (DEPTH=16) → `cnt`=16, `full`=1, `almost_full` asserted from the 12th push; pop all → data 0x01..0x10 in order, `empty`=1.
- Push while full with 0xAA → `cnt` stays 16, contents unchanged, `overflow`=1. Pulse `err_clr` → `overflow`=0.
- Pop while empty → `cnt` stays 0, `underflow`=1. Push+pop while empty with 0x5A → `cnt`=1, `data_out`=0x5A, `underflow`=1.
- Push+pop while full with 0x77 → head advances, `cnt`=16. Drain → 0x77 is the last entry, confirming pointer wrap.
- Fill 10 entries, assert `flush` with `push`=1 → `cnt`=0, `empty`=1, no overflow or underflow.
- Assert `FIFO_clr` asynchronously mid-burst → all outputs at reset values before the next clock edge. Repeat with `SYNC_FIFO_ERR_EN` undefined: error flags are always 0.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with thresholds, flush and sticky errors
// Define SYNC_FIFO_ERR_EN to implement overflow/underflow flags and err_clr.
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             FIFO_clr,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full         = (r_cnt == CNT_W'(DEPTH));
    assign empty        = (r_cnt == '0);
    assign almost_full  = (r_cnt >= CNT_W'(AF_THRESH));
    assign almost_empty = (r_cnt <= CNT_W'(AE_THRESH));
    assign cnt          = r_cnt;
    assign data_out     = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk or posedge FIFO_clr) begin
        if (FIFO_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge FIFO_clr) begin
        if (FIFO_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = push & ~w_push_ok;
    assign w_unf_set = pop & ~w_pop_ok;

    // A new rejection in the err_clr cycle keeps the flag set.
    always_ff @(posedge clk or posedge FIFO_clr) begin
        if (FIFO_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow & ~err_clr);
            r_underflow <= w_unf_set | (r_underflow & ~err_clr);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (DEPTH=16)
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk;
    logic       FIFO_clr;
    logic       flush;
    logic       push;
    logic       pop;
    logic [7:0] data_in;
    logic       err_clr;
    logic [7:0] data_out;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_err;

    sync_fifo #(
        .WIDTH     (8),
        .DEPTH     (16),
        .AF_THRESH (12),
        .AE_THRESH (4)
    ) u_dut (
        .clk          (clk),
        .FIFO_clr     (FIFO_clr),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .cnt          (cnt),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cnt"},   32'(cnt), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full), 32'd0);
        check({tag, "_ae"},    32'(almost_empty), 32'd1);
        check({tag, "_af"},    32'(almost_full), 32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
        check({tag, "_unf"},   32'(underflow), 32'd0);
        check({tag, "_dout"},  32'(data_out), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        FIFO_clr = 1'b1;
        data_in  = 8'h00;
        idle();
        #1;
        check_reset_state("reset");
        tick();
        tick();
        FIFO_clr = 1'b0;

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            push    = 1'b1;
            data_in = 8'(i);
            tick();
            check("fill_cnt",  32'(cnt), 32'(i));
            check("fill_af",   32'(almost_full), 32'(i >= 12));
            check("fill_ae",   32'(almost_empty), 32'(i <= 4));
            check("fill_full", 32'(full), 32'(i == 16));
            check("fill_head", 32'(data_out), 32'h01);
        end

        data_in = 8'hAA;
        tick();
        check("ovf_cnt",  32'(cnt), 32'd16);
        check("ovf_head", 32'(data_out), 32'h01);
        check("ovf_flag", 32'(overflow), 32'(ERR));
        push    = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Drain: contents unchanged by the rejected 0xAA
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", 32'(data_out), 32'(i));
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("drain_cnt",   32'(cnt), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_unf",   32'(underflow), 32'd0);

        pop = 1'b1;
        tick();
        check("unf_cnt",  32'(cnt), 32'd0);
        check("unf_flag", 32'(underflow), 32'(ERR));
        push    = 1'b1;
        data_in = 8'h5A;
        tick();
        check("pp_empty_cnt",  32'(cnt), 32'd1);
        check("pp_empty_dout", 32'(data_out), 32'h5A);
        check("pp_empty_unf",  32'(underflow), 32'(ERR));
        push = 1'b0;
        pop  = 1'b0;

        // Rejected pop coinciding with err_clr keeps the flag
        pop = 1'b1;
        tick();
        check("pop5a_cnt", 32'(cnt), 32'd0);
        err_clr = 1'b1;
        tick();
        check("setwins_unf", 32'(underflow), 32'(ERR));
        pop = 1'b0;
        tick();
        err_clr = 1'b0;
        check("errclr_unf", 32'(underflow), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            push    = 1'b1;
            data_in = 8'(8'h20 + i);
            tick();
        end
        check("refill_full", 32'(full), 32'd1);
        check("refill_head", 32'(data_out), 32'h21);
        pop     = 1'b1;
        data_in = 8'h77;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        check("pp_full_cnt",  32'(cnt), 32'd16);
        check("pp_full_head", 32'(data_out), 32'h22);
        check("pp_full_ovf",  32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("wrap_data", 32'(data_out), (i < 15) ? 32'(8'h22 + i) : 32'h77);
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("wrap_empty", 32'(empty), 32'd1);

        // Flush with a concurrent push; underflow set beforehand must clear
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("pre_flush_unf", 32'(underflow), 32'(ERR));
        for (int i = 0; i < 10; i++) begin
            push    = 1'b1;
            data_in = 8'(8'h40 + i);
            tick();
        end
        check("pre_flush_cnt", 32'(cnt), 32'd10);
        flush   = 1'b1;
        data_in = 8'hEE;
        tick();
        flush = 1'b0;
        push  = 1'b0;
        check("flush_cnt",   32'(cnt), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_ovf",   32'(overflow), 32'd0);
        check("flush_unf",   32'(underflow), 32'd0);
        push    = 1'b1;
        data_in = 8'h3C;
        tick();
        push = 1'b0;
        check("post_flush_dout", 32'(data_out), 32'h3C);
        check("post_flush_cnt",  32'(cnt), 32'd1);

        // Async clear mid-burst, with underflow set first
        pop = 1'b1;
        tick();
        tick();
        check("pre_clr_unf", 32'(underflow), 32'(ERR));
        pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push    = 1'b1;
            data_in = 8'(8'h90 + i);
            tick();
        end
        check("pre_clr_cnt", 32'(cnt), 32'd3);
        #2;
        FIFO_clr = 1'b1;
        #1;
        check_reset_state("aclr");
        idle();
        tick();
        FIFO_clr = 1'b0;
        push     = 1'b1;
        data_in  = 8'h99;
        tick();
        push = 1'b0;
        check("post_clr_dout", 32'(data_out), 32'h99);
        check("post_clr_cnt",  32'(cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
